// File: rtl/mem_handshake_ctrl_if.sv
// Bus bundle between the CPU memory port and mem_handshake_ctrl.
// master = CPU side, slave = memory responder side.
interface mem_handshake_ctrl_if;
  logic [15:0] address_in;
  logic [15:0] data_in;
  logic        cpu_mem_enable;
  logic        cpu_mem_rw;
  logic [15:0] data_out;
  logic        mfc;

  modport master (
    output address_in, data_in, cpu_mem_enable, cpu_mem_rw,
    input  data_out, mfc
  );

  modport slave (
    input  address_in, data_in, cpu_mem_enable, cpu_mem_rw,
    output data_out, mfc
  );
endinterface

// File: rtl/mem_handshake_ctrl.sv
// Word-addressed memory responder with enable / rw / MFC handshake and
// a fixed number of wait states between request capture and access.
// Optional access statistics are enabled by defining MEMCTL_STATS_EN.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no request; capture address/rw/data when enable is seen
// S_WAIT | counting down wait states; enable low aborts the request
// S_DONE | access performed, mfc high until enable is dropped
module mem_handshake_ctrl #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  mem_handshake_ctrl_if.slave  bus
`ifdef MEMCTL_STATS_EN
  ,
  output logic [15:0]          read_count,
  output logic [15:0]          write_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [3:0]              wait_cnt;
  logic [DEPTH_LOG2-1:0]   req_addr;
  logic [15:0]             req_data;
  logic                    req_rw;
  logic                    accept;
  logic                    do_access;
  logic [15:0]             mem [2**DEPTH_LOG2];

  // Upper address bits are intentionally dropped so addresses alias modulo depth.
  generate
    if (DEPTH_LOG2 < 16) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^bus.address_in[15:DEPTH_LOG2];
    end
  endgenerate

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; enable low in WAIT aborts, in DONE releases.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.cpu_mem_enable) state_nxt = S_WAIT;
      S_WAIT: begin
        if (!bus.cpu_mem_enable)  state_nxt = S_IDLE;
        else if (wait_cnt == 4'd0) state_nxt = S_DONE;
      end
      S_DONE: if (!bus.cpu_mem_enable) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output and strobe decode.
  always_comb begin
    bus.mfc   = (state == S_DONE);
    accept    = (state == S_IDLE) && bus.cpu_mem_enable;
    do_access = (state == S_WAIT) && bus.cpu_mem_enable && (wait_cnt == 4'd0);
  end

  // Request capture, wait-state down-counter and registered read data.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt     <= 4'd0;
      req_addr     <= '0;
      req_data     <= 16'h0000;
      req_rw       <= 1'b0;
      bus.data_out <= 16'h0000;
    end else begin
      if (accept) begin
        req_addr <= bus.address_in[DEPTH_LOG2-1:0];
        req_data <= bus.data_in;
        req_rw   <= bus.cpu_mem_rw;
        wait_cnt <= 4'(WAIT_STATES);
      end else if (state == S_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (do_access && !req_rw) bus.data_out <= mem[req_addr];
    end
  end

  // RAM write port; kept free of reset so it maps to block RAM, but a
  // write landing on a reset edge is suppressed.
  always_ff @(posedge clock) begin
    if (!reset && do_access && req_rw) mem[req_addr] <= req_data;
  end

`ifdef MEMCTL_STATS_EN
  // Completed-access counters, bumped on the WAIT->DONE edge only.
  always_ff @(posedge clock) begin
    if (reset) begin
      read_count  <= 16'h0000;
      write_count <= 16'h0000;
    end else if (do_access) begin
      if (req_rw) write_count <= write_count + 16'd1;
      else        read_count  <= read_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_handshake_ctrl.sv
// Scoreboard bench for mem_handshake_ctrl: two instances (default wait
// states and zero wait states) share stimulus through a select mux.
module tb_mem_handshake_ctrl;

  typedef struct {
    logic [15:0] exp_dout;
    int          cyc;
    string       name;
  } sb_t;

  logic        clock;
  logic        reset;
  logic        en;
  logic        sel;
  logic        rw_r;
  logic [15:0] addr_r;
  logic [15:0] data_r;
  logic        mfc_m;
  logic [15:0] dout_m;
  logic        mfc_d;
  int          cycle_cnt;
  int          tests;
  int          fails;
  sb_t         sb_q[$];

  mem_handshake_ctrl_if bus_a ();
  mem_handshake_ctrl_if bus_b ();

`ifdef MEMCTL_STATS_EN
  logic [15:0] rc_a, wc_a, rc_b, wc_b;
`endif

  assign bus_a.address_in     = addr_r;
  assign bus_a.data_in        = data_r;
  assign bus_a.cpu_mem_rw     = rw_r;
  assign bus_a.cpu_mem_enable = en & ~sel;
  assign bus_b.address_in     = addr_r;
  assign bus_b.data_in        = data_r;
  assign bus_b.cpu_mem_rw     = rw_r;
  assign bus_b.cpu_mem_enable = en & sel;
  assign mfc_m  = sel ? bus_b.mfc : bus_a.mfc;
  assign dout_m = sel ? bus_b.data_out : bus_a.data_out;

  mem_handshake_ctrl #(.DEPTH_LOG2(10), .WAIT_STATES(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
`ifdef MEMCTL_STATS_EN
    ,
    .read_count  (rc_a),
    .write_count (wc_a)
`endif
  );

  mem_handshake_ctrl #(.DEPTH_LOG2(10), .WAIT_STATES(0)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
`ifdef MEMCTL_STATS_EN
    ,
    .read_count  (rc_b),
    .write_count (wc_b)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cycle_cnt = 0;
  always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every rising mfc must match the oldest queued expectation.
  initial mfc_d = 1'b0;
  always @(negedge clock) begin
    if (mfc_m && !mfc_d) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_mfc", 32'(cycle_cnt), 32'hFFFF_FFFF);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk({e.name, "_latency"}, 32'(cycle_cnt), 32'(e.cyc));
        chk({e.name, "_data_out"}, {16'h0, dout_m}, {16'h0, e.exp_dout});
      end
    end
    mfc_d = mfc_m;
  end

  task automatic wait_mfc(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (mfc_m) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout actual=mfc_low required=mfc_high", name);
    end
  endtask

  // One full handshake; exp_dout is the data_out value expected when mfc rises.
  task automatic access(input string name, input logic rw, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_dout, input int hold);
    int ws;
    ws = sel ? 0 : 2;
    @(negedge clock);
    addr_r = addr;
    data_r = wdata;
    rw_r   = rw;
    en     = 1'b1;
    sb_q.push_back('{exp_dout, cycle_cnt + 2 + ws, name});
    wait_mfc(name);
    for (int i = 0; i < hold; i++) begin
      addr_r = 16'h0006;
      data_r = 16'hDEAD;
      rw_r   = 1'b1;
      @(negedge clock);
      chk({name, "_hold_mfc"}, {31'h0, mfc_m}, 32'h1);
      chk({name, "_hold_dout"}, {16'h0, dout_m}, {16'h0, exp_dout});
    end
    en = 1'b0;
    @(negedge clock);
    chk({name, "_mfc_fall"}, {31'h0, mfc_m}, 32'h0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    en = 1'b0;
    sel = 1'b0;
    rw_r = 1'b0;
    addr_r = 16'h0000;
    data_r = 16'h0000;
    repeat (3) @(negedge clock);
    chk("rst_mfc_a", {31'h0, bus_a.mfc}, 32'h0);
    chk("rst_dout_a", {16'h0, bus_a.data_out}, 32'h0);
    chk("rst_mfc_b", {31'h0, bus_b.mfc}, 32'h0);
    chk("rst_dout_b", {16'h0, bus_b.data_out}, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    // Basic write/read and address aliasing.
    access("wr_06",   1'b1, 16'h0006, 16'h1B1E, 16'h0000, 0);
    access("rd_06",   1'b0, 16'h0006, 16'h0000, 16'h1B1E, 0);
    access("wr_ffeb", 1'b1, 16'hFFEB, 16'hFFEB, 16'h1B1E, 0);
    access("rd_03eb", 1'b0, 16'h03EB, 16'h0000, 16'hFFEB, 0);
    access("wr_0000", 1'b1, 16'h0000, 16'h0C0C, 16'hFFEB, 0);
    access("rd_0400", 1'b0, 16'h0400, 16'h0000, 16'h0C0C, 0);

    // Abort: enable dropped while the counter has reached zero.
    access("wr_10", 1'b1, 16'h0010, 16'hAAAA, 16'h0C0C, 0);
    @(negedge clock);
    addr_r = 16'h0010;
    data_r = 16'h5555;
    rw_r   = 1'b1;
    en     = 1'b1;
    repeat (3) @(negedge clock);
    en = 1'b0;
    repeat (4) @(negedge clock);
    chk("abort_mfc", {31'h0, mfc_m}, 32'h0);
    chk("abort_dout", {16'h0, dout_m}, 32'h0C0C);
    access("rd_10_after_abort", 1'b0, 16'h0010, 16'h0000, 16'hAAAA, 0);

    // Reset while in DONE of a read.
    access("wr_20", 1'b1, 16'h0020, 16'h1234, 16'hAAAA, 0);
    @(negedge clock);
    addr_r = 16'h0020;
    rw_r   = 1'b0;
    en     = 1'b1;
    sb_q.push_back('{16'h1234, cycle_cnt + 4, "rd_20"});
    wait_mfc("rd_20");
    reset = 1'b1;
    @(negedge clock);
    chk("rst_done_mfc", {31'h0, mfc_m}, 32'h0);
    chk("rst_done_dout", {16'h0, dout_m}, 32'h0);
    reset = 1'b0;
    en = 1'b0;
    @(negedge clock);

    // Reset landing on the edge a write would commit.
    addr_r = 16'h0020;
    data_r = 16'h9999;
    rw_r   = 1'b1;
    en     = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_wait_mfc", {31'h0, mfc_m}, 32'h0);
    reset = 1'b0;
    en = 1'b0;
    @(negedge clock);
    access("rd_20_after_rst", 1'b0, 16'h0020, 16'h0000, 16'h1234, 0);

    // Enable held high after completion; inputs change but are ignored.
    access("rd_06_hold", 1'b0, 16'h0006, 16'h0000, 16'h1B1E, 5);
    access("rd_06_recheck", 1'b0, 16'h0006, 16'h0000, 16'h1B1E, 0);

    // Zero wait states instance.
    sel = 1'b1;
    @(negedge clock);
    access("z_wr_1", 1'b1, 16'h0001, 16'h1111, 16'h0000, 0);
    access("z_wr_2", 1'b1, 16'h0002, 16'h2222, 16'h0000, 0);
    access("z_wr_3", 1'b1, 16'h0003, 16'h3333, 16'h0000, 0);
    access("z_rd_2", 1'b0, 16'h0002, 16'h0000, 16'h2222, 0);
    access("z_rd_3", 1'b0, 16'h0003, 16'h0000, 16'h3333, 0);
`ifdef MEMCTL_STATS_EN
    chk("z_write_count", {16'h0, wc_b}, 32'd3);
    chk("z_read_count", {16'h0, rc_b}, 32'd2);
`endif
    repeat (2) @(negedge clock);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
